// File: rtl/dn_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : dn_streamer_if
// Brief    : Byte-stream input and ROM download output bundle of dn_streamer.
// Revision : 1.0  initial release
// ============================================================================
interface dn_streamer_if #(
   parameter int ADDR_W = 14
);
   logic              s_valid;
   logic [7:0]        s_data;
   logic              s_ready;
   logic [ADDR_W-1:0] dn_addr;
   logic [7:0]        dn_data;
   logic              dn_wr;
   logic [7:0]        dn_index;
   logic              dn_download;
   logic              done;
   logic              err;

   // master: the streamer itself; slave: upstream source plus ROM consumers
   modport master (
      input  s_valid, s_data,
      output s_ready, dn_addr, dn_data, dn_wr, dn_index, dn_download, done, err
   );
   modport slave (
      output s_valid, s_data,
      input  s_ready, dn_addr, dn_data, dn_wr, dn_index, dn_download, done, err
   );
endinterface
`default_nettype wire

// File: rtl/dn_streamer.sv
`default_nettype none
// ============================================================================
// Module   : dn_streamer
// Brief    : Decodes a framed byte stream into dn_wr strobes with checksum.
// Revision : 1.0  initial release
// ============================================================================
module dn_streamer #(
   parameter int ADDR_W = 14,
   parameter int WR_GAP = 0
) (
   input  wire logic clk_sys,
   input  wire logic reset,
   dn_streamer_if.master bus
);
   localparam int c_GAP_W = (WR_GAP < 2) ? 1 : $clog2(WR_GAP);
   localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'((WR_GAP > 0) ? (WR_GAP - 1) : 0);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_A_LO = 3'd1,
      S_A_HI = 3'd2,
      S_L_LO = 3'd3,
      S_L_HI = 3'd4,
      S_DATA = 3'd5,
      S_GAP  = 3'd6,
      S_CSUM = 3'd7
   } state_t;

   state_t            r_state;
   logic              r_ready;
   logic [7:0]        r_lo;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_dn_addr;
   logic [7:0]        r_dn_data;
   logic [7:0]        r_index;
   logic [7:0]        r_sum;
   logic [16:0]       r_cnt;
   logic [c_GAP_W-1:0] r_gap;
   logic              r_wr;
   logic              r_dl;
   logic              r_done;
   logic              r_err;

   logic              w_accept;
   logic [15:0]       w_hdr;
   logic              w_last;

   assign w_accept = bus.s_valid && r_ready;
   assign w_hdr    = {bus.s_data, r_lo};
   assign w_last   = (r_cnt == 17'd1);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_ready   <= 1'b0;
         r_lo      <= '0;
         r_addr    <= '0;
         r_dn_addr <= '0;
         r_dn_data <= '0;
         r_index   <= '0;
         r_sum     <= '0;
         r_cnt     <= '0;
         r_gap     <= '0;
         r_wr      <= 1'b0;
         r_dl      <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_wr    <= 1'b0;
         r_done  <= 1'b0;
         r_ready <= 1'b1;
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_index <= bus.s_data;
               r_err   <= 1'b0;
               r_dl    <= 1'b1;
               r_sum   <= '0;
               r_state <= S_A_LO;
            end
            S_A_LO: if (w_accept) begin
               r_lo    <= bus.s_data;
               r_state <= S_A_HI;
            end
            S_A_HI: if (w_accept) begin
               // header address bits above ADDR_W are dropped here
               r_addr  <= ADDR_W'(w_hdr);
               r_state <= S_L_LO;
            end
            S_L_LO: if (w_accept) begin
               r_lo    <= bus.s_data;
               r_state <= S_L_HI;
            end
            S_L_HI: if (w_accept) begin
               r_cnt   <= {1'b0, w_hdr} + 17'd1;
               r_state <= S_DATA;
            end
            S_DATA: if (w_accept) begin
               r_wr      <= 1'b1;
               r_dn_data <= bus.s_data;
               r_dn_addr <= r_addr;
               r_addr    <= r_addr + ADDR_W'(1);
               r_sum     <= r_sum + bus.s_data;
               r_cnt     <= r_cnt - 17'd1;
               if (WR_GAP > 0) begin
                  r_state <= S_GAP;
                  r_ready <= 1'b0;
                  r_gap   <= c_GAP_LOAD;
               end else if (w_last) begin
                  r_state <= S_CSUM;
               end
            end
            S_GAP: begin
               // r_cnt was already decremented for the byte that opened the gap
               if (r_gap == '0) begin
                  r_state <= (r_cnt == 17'd0) ? S_CSUM : S_DATA;
               end else begin
                  r_gap   <= r_gap - c_GAP_W'(1);
                  r_ready <= 1'b0;
               end
            end
            S_CSUM: if (w_accept) begin
               r_done  <= 1'b1;
               r_dl    <= 1'b0;
               r_err   <= (bus.s_data != r_sum);
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.s_ready     = r_ready;
   assign bus.dn_addr     = r_dn_addr;
   assign bus.dn_data     = r_dn_data;
   assign bus.dn_wr       = r_wr;
   assign bus.dn_index    = r_index;
   assign bus.dn_download = r_dl;
   assign bus.done        = r_done;
   assign bus.err         = r_err;
endmodule
`default_nettype wire

// File: tb/tb_dn_streamer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dn_streamer
// Brief    : Directed scoreboard bench for dn_streamer, WR_GAP 0 and 3.
// Revision : 1.0  initial release
// ============================================================================
module tb_dn_streamer;
   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   always #5 clk_sys = ~clk_sys;

   dn_streamer_if #(.ADDR_W(14)) if0 ();
   dn_streamer_if #(.ADDR_W(14)) if3 ();

   dn_streamer #(.ADDR_W(14), .WR_GAP(0)) u_dut0 (.clk_sys(clk_sys), .reset(reset), .bus(if0));
   dn_streamer #(.ADDR_W(14), .WR_GAP(3)) u_dut3 (.clk_sys(clk_sys), .reset(reset), .bus(if3));

   typedef struct packed {
      logic [13:0] addr;
      logic [7:0]  data;
      logic [7:0]  idx;
   } wr_t;

   wr_t  q0[$], q3[$];
   logic qd0[$], qd3[$];
   int   t0[$], t3[$];
   logic [7:0] pl[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   low3 = 0;
   logic prev_wr3 = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic get_ready(input int sel);
      return (sel == 0) ? if0.s_ready : if3.s_ready;
   endfunction
   function automatic logic get_err(input int sel);
      return (sel == 0) ? if0.err : if3.err;
   endfunction
   function automatic logic get_dl(input int sel);
      return (sel == 0) ? if0.dn_download : if3.dn_download;
   endfunction

   task automatic drive(input int sel, input logic v, input logic [7:0] d);
      if (sel == 0) begin if0.s_valid = v; if0.s_data = d; end
      else          begin if3.s_valid = v; if3.s_data = d; end
   endtask

   // called at a negedge; returns at the negedge right after acceptance
   task automatic send_byte(input int sel, input logic [7:0] b, input bit rnd);
      int n;
      if (rnd) begin
         drive(sel, 1'b0, 8'h00);
         repeat ($urandom_range(0, 3)) @(negedge clk_sys);
      end
      drive(sel, 1'b1, b);
      n = 0;
      while (!get_ready(sel) && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      if (n >= 200) check("ready_timeout", 32'(n), 32'd0);
      @(negedge clk_sys);
   endtask

   task automatic send_frame(input int sel, input logic [7:0] idx, input logic [15:0] a,
                             input bit bad, input bit rnd, input int stop_after);
      logic [7:0]  sum;
      logic [7:0]  cs;
      logic [15:0] lm1;
      wr_t         e;
      int          n;
      n   = pl.size();
      lm1 = 16'(n - 1);
      sum = 8'h00;
      foreach (pl[i]) sum += pl[i];
      cs = bad ? 8'h00 : sum;
      send_byte(sel, idx, rnd);
      check("err_clear_on_index", 32'(get_err(sel)), 32'd0);
      check("download_on_index", 32'(get_dl(sel)), 32'd1);
      send_byte(sel, a[7:0], rnd);
      send_byte(sel, a[15:8], rnd);
      send_byte(sel, lm1[7:0], rnd);
      send_byte(sel, lm1[15:8], rnd);
      for (int i = 0; i < n; i++) begin
         if (i == stop_after) begin
            drive(sel, 1'b0, 8'h00);
            return;
         end
         e.addr = a[13:0] + 14'(i);
         e.data = pl[i];
         e.idx  = idx;
         if (sel == 0) q0.push_back(e); else q3.push_back(e);
         send_byte(sel, pl[i], rnd);
      end
      if (sel == 0) qd0.push_back(cs != sum); else qd3.push_back(cs != sum);
      send_byte(sel, cs, rnd);
      drive(sel, 1'b0, 8'h00);
   endtask

   always @(posedge clk_sys) cyc <= cyc + 1;

   always @(negedge clk_sys) begin
      wr_t e;
      logic ed;
      if (if0.dn_wr) begin
         t0.push_back(cyc);
         check("wr0_expected", 32'(q0.size() != 0), 32'd1);
         if (q0.size() != 0) begin
            e = q0.pop_front();
            check("wr0_addr", 32'(if0.dn_addr), 32'(e.addr));
            check("wr0_data", 32'(if0.dn_data), 32'(e.data));
            check("wr0_index", 32'(if0.dn_index), 32'(e.idx));
         end
      end
      if (if0.done) begin
         check("done0_expected", 32'(qd0.size() != 0), 32'd1);
         if (qd0.size() != 0) begin
            ed = qd0.pop_front();
            check("done0_err", 32'(if0.err), 32'(ed));
            check("done0_download", 32'(if0.dn_download), 32'd0);
         end
      end
      if (if3.dn_wr) begin
         t3.push_back(cyc);
         check("wr3_not_back_to_back", 32'(prev_wr3), 32'd0);
         check("wr3_expected", 32'(q3.size() != 0), 32'd1);
         if (q3.size() != 0) begin
            e = q3.pop_front();
            check("wr3_addr", 32'(if3.dn_addr), 32'(e.addr));
            check("wr3_data", 32'(if3.dn_data), 32'(e.data));
         end
      end
      if (if3.done) begin
         check("done3_expected", 32'(qd3.size() != 0), 32'd1);
         if (qd3.size() != 0) begin
            ed = qd3.pop_front();
            check("done3_err", 32'(if3.err), 32'(ed));
         end
      end
      if (!if3.s_ready) low3 <= low3 + 1;
      prev_wr3 <= if3.dn_wr;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(0, 1'b0, 8'h00);
      drive(3, 1'b0, 8'h00);
      repeat (2) @(negedge clk_sys);
      check("rst_ready", 32'(if0.s_ready), 32'd0);
      check("rst_download", 32'(if0.dn_download), 32'd0);
      check("rst_outputs", {if0.dn_wr, if0.done, if0.err, if0.dn_index, if0.dn_addr}, 32'd0);
      reset = 1'b0;
      @(negedge clk_sys);
      check("ready_after_rst", 32'(if0.s_ready), 32'd1);

      // basic frame, checksum 0x31 correct
      pl = '{8'hAA, 8'hBB, 8'hCC};
      t0.delete();
      send_frame(0, 8'h01, 16'h0010, 1'b0, 1'b0, 99);
      repeat (3) @(negedge clk_sys);
      check("consecutive_writes", 32'(t0[2] - t0[0]), 32'd2);
      check("index_held", 32'(if0.dn_index), 32'd1);
      check("download_low_after", 32'(if0.dn_download), 32'd0);
      check("err_after_good", 32'(if0.err), 32'd0);

      // same frame, checksum 00 -> sticky err
      send_frame(0, 8'h01, 16'h0010, 1'b1, 1'b0, 99);
      repeat (5) @(negedge clk_sys);
      check("err_sticky", 32'(if0.err), 32'd1);

      // address wrap; addr_hi bits 7:6 set must be ignored
      pl = '{8'h5A, 8'hA5};
      send_frame(0, 8'h00, 16'hFFFF, 1'b0, 1'b0, 99);
      repeat (3) @(negedge clk_sys);
      check("index_zero", 32'(if0.dn_index), 32'd0);

      // gap instance with s_valid held high
      pl = '{8'h11, 8'h22};
      t3.delete();
      low3 = 0;
      send_frame(3, 8'h00, 16'h0020, 1'b0, 1'b0, 99);
      check("gap_ready_low_cycles", 32'(low3), 32'd6);
      repeat (3) @(negedge clk_sys);
      check("gap_wr_spacing", 32'(t3[1] - t3[0]), 32'd4);

      // reset after 2 of 4 payload bytes
      pl = '{8'h01, 8'h02, 8'h03, 8'h04};
      send_frame(0, 8'h01, 16'h0040, 1'b0, 1'b0, 2);
      reset = 1'b1;
      @(negedge clk_sys);
      check("abort_download", 32'(if0.dn_download), 32'd0);
      check("abort_ready", 32'(if0.s_ready), 32'd0);
      @(negedge clk_sys);
      reset = 1'b0;
      repeat (4) @(negedge clk_sys);
      check("abort_no_pending", 32'(q0.size() + qd0.size()), 32'd0);
      pl = '{8'h10, 8'h20, 8'h30};
      send_frame(0, 8'h00, 16'h0100, 1'b0, 1'b0, 99);
      repeat (3) @(negedge clk_sys);
      check("after_abort_err", 32'(if0.err), 32'd0);

      // random s_valid over a 16-byte frame, and a short one on the gap instance
      pl.delete();
      for (int i = 0; i < 16; i++) pl.push_back(8'($urandom));
      t0.delete();
      send_frame(0, 8'h01, 16'h0200, 1'b0, 1'b1, 99);
      pl = '{8'h7F, 8'h80, 8'hFE, 8'h01, 8'h55};
      send_frame(3, 8'h01, 16'h3FFD, 1'b0, 1'b1, 99);
      repeat (6) @(negedge clk_sys);
      check("rand_write_count", 32'(t0.size()), 32'd16);
      check("queues_drained", 32'(q0.size() + q3.size() + qd0.size() + qd3.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
